// File: rtl/traffic_light_monitor_if.sv
// Light-bus monitor interface: controller-side inputs plus monitor status outputs.
interface traffic_light_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             clear;
  logic [2:0]       light_in;
  logic             fault;
  logic [3:0]       fault_flags;
  logic [1:0]       first_fault;
  logic [1:0]       obs_state;
  logic [CNT_W-1:0] dwell;
  logic [15:0]      cycle_cnt;

  // Side that drives the light bus and control, and reads status.
  modport master (
    output en, clear, light_in,
    input  fault, fault_flags, first_fault, obs_state, dwell, cycle_cnt
  );

  // Monitor side.
  modport slave (
    input  en, clear, light_in,
    output fault, fault_flags, first_fault, obs_state, dwell, cycle_cnt
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the one-hot traffic light bus: tracks RED->GREEN->YELLOW,
// per-state dwell, sticky fault flags and completed light cycles.
module traffic_light_monitor #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MIN_RED    = 1,
  parameter int unsigned MIN_GREEN  = 1,
  parameter int unsigned MIN_YELLOW = 1,
  parameter int unsigned MAX_DWELL  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  traffic_light_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_RED    = 2'd1,
    ST_GREEN  = 2'd2,
    ST_YELLOW = 2'd3
  } state_e;

  localparam logic [2:0]       L_RED     = 3'b001;
  localparam logic [2:0]       L_GREEN   = 3'b010;
  localparam logic [2:0]       L_YELLOW  = 3'b100;
  localparam logic [CNT_W-1:0] DWELL_SAT = '1;
  localparam logic [15:0]      CYC_SAT   = 16'hFFFF;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [15:0]      cyc_q, cyc_d;
  logic [3:0]       flags_q, flags_d;
  logic [1:0]       first_q, first_d;
  logic             fault_q, fault_d;

  logic             illegal;
  logic [2:0]       cur_light;
  logic [2:0]       succ_light;
  state_e           succ_state;
  logic [CNT_W-1:0] min_dwell;
  logic [3:0]       set_flags;
  logic [3:0]       base_flags;
  logic [1:0]       base_first;

  assign illegal = (mon.light_in != L_RED) && (mon.light_in != L_GREEN) &&
                   (mon.light_in != L_YELLOW);

  // Per-state expected light, legal successor and minimum dwell.
  always_comb begin
    cur_light  = L_RED;
    succ_light = L_GREEN;
    succ_state = ST_GREEN;
    min_dwell  = CNT_W'(MIN_RED);
    case (state_q)
      ST_GREEN: begin
        cur_light  = L_GREEN;
        succ_light = L_YELLOW;
        succ_state = ST_YELLOW;
        min_dwell  = CNT_W'(MIN_GREEN);
      end
      ST_YELLOW: begin
        cur_light  = L_YELLOW;
        succ_light = L_RED;
        succ_state = ST_RED;
        min_dwell  = CNT_W'(MIN_YELLOW);
      end
      default: ;
    endcase
  end

  // Next-state tracking, fault detection and sticky flag update.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    cyc_d     = cyc_q;
    set_flags = 4'b0000;

    if (!mon.en) begin
      state_d = ST_SYNC;
      dwell_d = '0;
    end else if (state_q == ST_SYNC) begin
      if (illegal) begin
        set_flags[0] = 1'b1;
      end else if (mon.light_in == L_RED) begin
        state_d = ST_RED;
        dwell_d = CNT_W'(1);
      end
    end else if (illegal) begin
      set_flags[0] = 1'b1;
      state_d      = ST_SYNC;
      dwell_d      = '0;
    end else if (mon.light_in == cur_light) begin
      if (dwell_q == CNT_W'(MAX_DWELL)) set_flags[3] = 1'b1;
      if (dwell_q != DWELL_SAT) dwell_d = dwell_q + CNT_W'(1);
    end else if (mon.light_in == succ_light) begin
      if (dwell_q < min_dwell) set_flags[2] = 1'b1;
      state_d = succ_state;
      dwell_d = CNT_W'(1);
      if (state_q == ST_YELLOW && cyc_q != CYC_SAT) cyc_d = cyc_q + 16'd1;
    end else begin
      set_flags[1] = 1'b1;
      state_d      = ST_SYNC;
      dwell_d      = '0;
    end

    // Clear applies first so a same-cycle fault lands on a clean slate.
    base_flags = mon.clear ? 4'b0000 : flags_q;
    base_first = mon.clear ? 2'd0 : first_q;
    flags_d    = base_flags | set_flags;
    first_d    = base_first;
    if (base_flags == 4'b0000 && set_flags != 4'b0000) begin
      if (set_flags[0])      first_d = 2'd0;
      else if (set_flags[1]) first_d = 2'd1;
      else if (set_flags[2]) first_d = 2'd2;
      else                   first_d = 2'd3;
    end
    fault_d = |flags_d;
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      dwell_q <= '0;
      cyc_q   <= '0;
      flags_q <= '0;
      first_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      cyc_q   <= cyc_d;
      flags_q <= flags_d;
      first_q <= first_d;
      fault_q <= fault_d;
    end
  end

  assign mon.obs_state   = 2'(state_q);
  assign mon.dwell       = dwell_q;
  assign mon.cycle_cnt   = cyc_q;
  assign mon.fault_flags = flags_q;
  assign mon.first_fault = first_q;
  assign mon.fault       = fault_q;

endmodule
